// File: rtl/lcd_cmd_feeder.sv
// lcd_cmd_feeder: FIFO-buffered command issuer for the LCD controller; stops after WRITE and reports completion.
// Optional LCD_CMD_FEEDER_CNT_EN adds issued_cnt and last_err_code.
module lcd_cmd_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [3:0]    cmd_in,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic          drop_err,
`ifdef LCD_CMD_FEEDER_CNT_EN
    output logic [7:0]    issued_cnt,
    output logic [3:0]    last_err_code,
`endif
    output logic          seq_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, PULSE, GAP, WAIT_DONE, FIN} state_t;
    state_t state, next;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          valid_code, push_ok, pop;
    assign valid_code = cmd_in <= 4'd11;
    // full is sampled before this cycle's pop, so a push into a full FIFO is rejected even when popping
    assign push_ok    = push && !full && valid_code;
    assign pop        = (state == ISSUE) && !busy && !empty;
    assign full       = level == (AW+1)'(DEPTH);
    assign empty      = level == '0;
    assign cmd_valid  = state == PULSE;
    assign seq_done   = state == FIN;
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= cmd_in;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            cmd      <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= next;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cmd    <= mem[rd_ptr];
            end
            if (push_ok && !pop) level <= level + (AW+1)'(1);
            else if (pop && !push_ok) level <= level - (AW+1)'(1);
            if (push && (full || !valid_code)) drop_err <= 1'b1;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = empty ? IDLE : ISSUE;
            ISSUE:     next = pop ? PULSE : ISSUE;
            PULSE:     next = (cmd == 4'd0) ? WAIT_DONE : GAP;
            GAP:       next = empty ? IDLE : ISSUE;
            WAIT_DONE: next = done ? FIN : WAIT_DONE;
            FIN:       next = FIN;
            default:   next = IDLE;
        endcase
    end
`ifdef LCD_CMD_FEEDER_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt    <= '0;
            last_err_code <= '0;
        end else begin
            if (cmd_valid && issued_cnt != 8'hff) issued_cnt <= issued_cnt + 8'd1;
            if (push && !valid_code) last_err_code <= cmd_in;
        end
    end
`endif
endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// tb_lcd_cmd_feeder: directed and randomized checks of lcd_cmd_feeder against a queue-based reference model.
module tb_lcd_cmd_feeder;
    localparam int DEPTH = 16;
    logic       clk = 0, reset = 1, push = 0, busy = 0, done = 0;
    logic [3:0] cmd_in = 0;
    logic       full, empty, cmd_valid, drop_err, seq_done;
    logic [4:0] level;
    logic [3:0] cmd;
`ifdef LCD_CMD_FEEDER_CNT_EN
    logic [7:0] issued_cnt;
    logic [3:0] last_err_code;
`endif
    lcd_cmd_feeder #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .reset(reset), .push(push), .cmd_in(cmd_in),
        .full(full), .empty(empty), .level(level), .cmd(cmd), .cmd_valid(cmd_valid),
        .busy(busy), .done(done), .drop_err(drop_err),
`ifdef LCD_CMD_FEEDER_CNT_EN
        .issued_cnt(issued_cnt), .last_err_code(last_err_code),
`endif
        .seq_done(seq_done)
    );
    always #5 clk = ~clk;

    int checks = 0, errors = 0, pulses = 0, bad_issue = 0;

    // Reference model: a queue of accepted codes plus a few flags describing the issuer's situation
    logic [3:0] q[$];
    bit         m_valid, m_armed, m_wait, m_fin, m_err;
    logic [3:0] m_cmd, m_last;
    int         m_cnt, sz;
    bit         acc, m_pop, m_idle;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_valid = 0; m_armed = 0; m_wait = 0; m_fin = 0; m_err = 0;
            m_cmd = 0; m_last = 0; m_cnt = 0;
        end else begin
            sz     = q.size();
            acc    = push && sz < DEPTH && cmd_in <= 11;
            if (push && !acc) m_err = 1;
            if (push && cmd_in > 11) m_last = cmd_in;
            m_pop  = m_armed && !busy && sz > 0;
            m_idle = !m_valid && !m_wait && !m_fin && !m_armed;
            if (m_valid && m_cnt < 255) m_cnt++;
            m_fin   = m_fin || (m_wait && done);
            m_wait  = m_wait ? !done : (m_valid && m_cmd == 0);
            m_armed = m_armed ? !m_pop : (m_idle && sz > 0);
            if (m_pop) m_cmd = q.pop_front();
            m_valid = m_pop;
            if (acc) q.push_back(cmd_in);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        if (m_valid) chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("drop_err", 32'(drop_err), 32'(m_err));
        chk("seq_done", 32'(seq_done), 32'(m_fin));
`ifdef LCD_CMD_FEEDER_CNT_EN
        chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
        chk("last_err_code", 32'(last_err_code), 32'(m_last));
`endif
        if (cmd_valid) pulses++;
        if (cmd_valid && cmd == 4'd10) bad_issue++;
    endtask

    task automatic do_reset();
        reset = 1; push = 0; busy = 0; done = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic push_one(input logic [3:0] code);
        push = 1; cmd_in = code;
        cyc();
        push = 0;
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
`ifdef LCD_CMD_FEEDER_CNT_EN
        chk("rst_issued_cnt", 32'(issued_cnt), 0);
        chk("rst_last_err", 32'(last_err_code), 0);
`endif
        // single push: pulse two cycles after the push edge
        push_one(4);
        cyc();
        chk("lat_early", 32'(cmd_valid), 0);
        cyc();
        chk("lat_valid", 32'(cmd_valid), 1);
        chk("lat_cmd", 32'(cmd), 4);
        chk("lat_level", 32'(level), 0);
        cyc();
        chk("lat_one_cycle", 32'(cmd_valid), 0);
        // sequence ending in WRITE
        pulses = 0;
        push_one(5); push_one(6); push_one(7); push_one(0);
        repeat (14) cyc();
        chk("seq_pulses", 32'(pulses), 4);
        push_one(9);
        repeat (5) cyc();
        chk("no_issue_after_write", 32'(pulses), 4);
        chk("seq_done_wait", 32'(seq_done), 0);
        done = 1;
        cyc();
        done = 0;
        chk("seq_done_set", 32'(seq_done), 1);
        repeat (3) cyc();
        chk("seq_done_hold", 32'(seq_done), 1);
        chk("seq_level_left", 32'(level), 1);
        // long busy stall
        do_reset();
        busy = 1;
        push_one(1); push_one(2); push_one(3);
        pulses = 0;
        repeat (70) cyc();
        chk("busy_stall", 32'(pulses), 0);
        busy = 0;
        cyc();
        chk("busy_release_valid", 32'(cmd_valid), 1);
        chk("busy_release_cmd", 32'(cmd), 1);
        repeat (8) cyc();
        // fill to full, then overflow
        do_reset();
        busy = 1;
        for (int i = 0; i < 16; i++) push_one(4'((i % 9) + 1));
        chk("full_flag", 32'(full), 1);
        chk("full_level", 32'(level), 16);
        chk("full_no_err", 32'(drop_err), 0);
        push_one(10);
        chk("overflow_err", 32'(drop_err), 1);
        chk("overflow_level", 32'(level), 16);
        busy = 0; pulses = 0; bad_issue = 0;
        repeat (60) cyc();
        chk("overflow_not_issued", 32'(bad_issue), 0);
        chk("drain_pulses", 32'(pulses), 16);
        chk("drain_empty", 32'(empty), 1);
        // invalid code
        do_reset();
        push_one(13);
        chk("inv_level", 32'(level), 0);
        chk("inv_err", 32'(drop_err), 1);
`ifdef LCD_CMD_FEEDER_CNT_EN
        chk("inv_last_err", 32'(last_err_code), 13);
`endif
        push_one(2);
        repeat (4) cyc();
`ifdef LCD_CMD_FEEDER_CNT_EN
        chk("inv_issued_cnt", 32'(issued_cnt), 1);
`endif
        // reset during a pulse
        do_reset();
        busy = 1;
        push_one(1); push_one(2); push_one(3); push_one(4);
        busy = 0;
        cyc();
        chk("pre_rst_valid", 32'(cmd_valid), 1);
        chk("pre_rst_level", 32'(level), 3);
        #2 reset = 1;
        #1;
        chk("async_rst_valid", 32'(cmd_valid), 0);
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_empty", 32'(empty), 1);
        @(negedge clk);
        reset = 0;
        pulses = 0;
        repeat (10) cyc();
        chk("post_rst_quiet", 32'(pulses), 0);
        push_one(7);
        cyc();
        cyc();
        chk("post_rst_valid", 32'(cmd_valid), 1);
        chk("post_rst_cmd", 32'(cmd), 7);
        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            push   = 1'($urandom_range(0, 1));
            cmd_in = (i == 300) ? 4'd0 : 4'($urandom_range(1, 15));
            busy   = $urandom_range(0, 3) == 0;
            done   = $urandom_range(0, 9) == 0;
            cyc();
        end
        push = 0; busy = 0; done = 0;
        repeat (4) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_cmd_feeder.md
Name: lcd_cmd_feeder

Overview:
- Command-issue stage directly upstream of the LCD controller.
- Buffers 4-bit image-processing commands pushed by the host/testbench in a small FIFO.
- Issues them to the controller with the cmd/cmd_valid/busy handshake, one command per grant.
- After issuing WRITE (code 0), stops issuing, waits for the controller's done, then reports sequence completion.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, 4: pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  host write strobe; cmd_in is enqueued when push=1 and full=0.
- cmd_in  in  4  command code, 0..11 valid.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  AW+1  current FIFO occupancy.
- cmd  out  4  command to the controller.
- cmd_valid  out  1  one-cycle issue pulse.
- busy  in  1  controller busy.
- done  in  1  controller finished output.
- drop_err  out  1  sticky flag: an invalid code or a push-while-full occurred.
- seq_done  out  1  sequence complete; holds high once set.

Behaviour:
- Reset values: cmd=0, cmd_valid=0, seq_done=0, drop_err=0, pointers=0, level=0, empty=1, full=0, state=IDLE. Reset mid-operation aborts any pulse or sequence immediately; FIFO contents are discarded.
- FIFO:
  - Registered, circular, wrap-around read and write pointers of width AW.
  - level is updated every cycle.
  - A push with full=1 is ignored and sets drop_err.
  - A push of a code >11 is not enqueued and sets drop_err.
  - Simultaneous push and pop while full: the pop proceeds and the push is rejected, because full is evaluated before the pop.
  - Simultaneous push and pop while empty: no pop; the push enqueues.
  - Simultaneous push and pop otherwise: level is unchanged.
- State machine:
  - IDLE: go to ISSUE when empty=0.
  - ISSUE: if busy=0 in this cycle, pop the head, register it into cmd, and drive cmd_valid=1 on the next cycle (state PULSE). Otherwise stay in ISSUE.
  - PULSE: cmd_valid=1 for exactly one cycle.
    - If cmd==0 (WRITE), go to WAIT_DONE.
    - Otherwise go to GAP.
  - GAP: one cycle with cmd_valid=0, so that busy, which the controller derives from cmd_valid, settles. Then go to IDLE if empty=1, or to ISSUE if empty=0.
  - WAIT_DONE: cmd_valid=0 and no pops; pushes are still accepted. When done=1, go to FIN.
  - FIN: seq_done=1, hold until reset. Remaining FIFO entries are never issued.
- Latency:
  - Push into an empty FIFO with busy=0: cmd_valid rises 2 cycles after the push edge (IDLE→ISSUE, then ISSUE→PULSE).
  - Back-to-back commands with busy held low: issue period is 3 cycles (ISSUE, PULSE, GAP).
- cmd holds its last value outside PULSE; only cmd_valid qualifies it.
- busy high during ISSUE stalls indefinitely. This includes the controller's initial image load.
- A done received before WRITE has been issued is ignored.

Optional Feature:
- Macro: LCD_CMD_FEEDER_CNT_EN.
- When defined:
  - Adds output issued_cnt, width 8: counts cmd_valid pulses and saturates at 255.
  - Adds output last_err_code, width 4: holds the last invalid code that was rejected.
  - Both reset to 0.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then busy=0, then push 4 (SHIFT_RIGHT) → cmd_valid=1 with cmd=4 exactly 2 cycles after the push; level returns to 0; a single one-cycle pulse.
- Push 5,6,7,0 with busy=0 → four pulses 3 cycles apart, codes in order 5,6,7,0. After the 0, no further pulses even if 9 is pushed. Pulse done=1 → seq_done=1 next cycle and held.
- Hold busy=1 for 70 cycles with 3 entries queued → no cmd_valid. Release busy → first pulse 1 cycle later, carrying the head code.
- Push 16 entries with busy=1, then push 1 more → full=1, level=16, drop_err=1, and the 17th code is never issued.
- Push code 13 → not enqueued, level unchanged, drop_err=1. With CNT_EN defined: last_err_code=13 and issued_cnt counts only valid issues.
- Assert reset during PULSE with 3 entries queued → cmd_valid=0 immediately, level=0, and no pulse after reset until a new push arrives.
